// File: rtl/comarray_sweep_reader_if.sv
// comarray_sweep_reader_if: valid/ready readout stream carrying (code, response) beats
//   out_valid  beat valid (master -> slave)
//   out_ready  sink accepts beat (slave -> master)
//   out_code   code of the current beat
//   out_resp   sampled response for out_code
interface comarray_sweep_reader_if #(
    parameter int WIDTH = 4,
    parameter int NOUT  = 3
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_code;
    logic [NOUT-1:0]  out_resp;
    modport master(output out_valid, out_code, out_resp, input out_ready);
    modport slave(input out_valid, out_code, out_resp, output out_ready);
endinterface

// File: rtl/comarray_sweep_reader.sv
// comarray_sweep_reader: sweeps a combinational array through all codes, records its truth table, streams it out
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     begin a sweep (honoured only when idle)
//   a_out     code driven to the function array
//   f_in      array response bits
//   busy      sweep or readout in progress
//   done      one-cycle pulse after the last readout beat
//   ones_cnt  per-output count of codes sampled as 1, field i = output i
//   o         readout stream (out_valid/out_ready/out_code/out_resp)
module comarray_sweep_reader #(
    parameter int WIDTH = 4,
    parameter int NOUT  = 3,
    parameter int HOLD  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [WIDTH-1:0]         a_out,
    input  logic [NOUT-1:0]          f_in,
    output logic                     busy,
    output logic                     done,
    output logic [NOUT*(WIDTH+1)-1:0] ones_cnt,
    comarray_sweep_reader_if.master  o
);
    localparam int CW = WIDTH + 1;
    localparam int DEPTH = 1 << WIDTH;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
    localparam logic [7:0] HLAST = 8'(HOLD - 1);
    typedef enum logic [1:0] {IDLE, DRIVE, DUMP, DONE} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      code_q, code_d, rd_q, rd_d;
    logic [7:0]         hold_q, hold_d;
    logic [NOUT*CW-1:0] ones_q, ones_d;
    logic [NOUT-1:0]    tbl_q [DEPTH];
    logic [NOUT-1:0]    tbl_d [DEPTH];
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        hold_d  = hold_q;
        rd_d    = rd_q;
        ones_d  = ones_q;
        tbl_d   = tbl_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = DRIVE;
                code_d  = '0;
                hold_d  = '0;
                ones_d  = '0;
            end
            DRIVE: if (hold_q == HLAST) begin
                // last hold cycle: the array has settled on this code, capture it
                tbl_d[code_q[WIDTH-1:0]] = f_in;
                for (int i = 0; i < NOUT; i++)
                    ones_d[i*CW +: CW] = ones_q[i*CW +: CW] + CW'(f_in[i]);
                if (code_q == LAST) begin
                    state_d = DUMP;
                    rd_d    = '0;
                end else begin
                    code_d = code_q + 1'b1;
                    hold_d = '0;
                end
            end else begin
                hold_d = hold_q + 1'b1;
            end
            DUMP: if (o.out_ready) begin
                if (rd_q == LAST) state_d = DONE;
                else rd_d = rd_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            hold_q  <= '0;
            rd_q    <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            hold_q  <= hold_d;
            rd_q    <= rd_d;
            ones_q  <= ones_d;
        end
    end
    // truth table is deliberately not cleared by reset
    always_ff @(posedge clk) tbl_q <= tbl_d;
    assign a_out       = (state_q == IDLE) ? '0 : code_q[WIDTH-1:0];
    assign busy        = (state_q == DRIVE) || (state_q == DUMP);
    assign done        = state_q == DONE;
    assign ones_cnt    = ones_q;
    assign o.out_valid = state_q == DUMP;
    assign o.out_code  = o.out_valid ? rd_q[WIDTH-1:0] : '0;
    assign o.out_resp  = o.out_valid ? tbl_q[rd_q[WIDTH-1:0]] : '0;
endmodule

// File: tb/tb_comarray_sweep_reader.sv
// tb_comarray_sweep_reader: directed bench for the sweep reader against a modelled 4-in/3-out array
module tb_comarray_sweep_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n, start_a, start_b;
    logic [3:0]  a_a, a_b;
    logic [2:0]  f_a, f_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [14:0] ones_a, ones_b;
    localparam logic [14:0] ONES = {5'd12, 5'd8, 5'd4};
    comarray_sweep_reader_if #(.WIDTH(4), .NOUT(3)) bus_a ();
    comarray_sweep_reader_if #(.WIDTH(4), .NOUT(3)) bus_b ();
    assign f_a = {a_a > 4'd3, ^a_a, a_a[0] & a_a[1]};
    assign f_b = {a_b > 4'd3, ^a_b, a_b[0] & a_b[1]};
    comarray_sweep_reader #(.WIDTH(4), .NOUT(3), .HOLD(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .a_out(a_a), .f_in(f_a),
        .busy(busy_a), .done(done_a), .ones_cnt(ones_a), .o(bus_a)
    );
    comarray_sweep_reader #(.WIDTH(4), .NOUT(3), .HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .a_out(a_b), .f_in(f_b),
        .busy(busy_b), .done(done_b), .ones_cnt(ones_b), .o(bus_b)
    );
    typedef struct {
        logic [3:0] code;
        logic [2:0] resp;
    } vec_t;
    vec_t vecs [16];
    int n_cmp = 0;
    int n_err = 0;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    // one full HOLD=2 run on dut_a; bp applies ready pattern 1,0,0,1; pulse pokes start while busy
    task automatic run_a(input bit bp, input bit pulse, input bit keep);
        int cyc;
        int idx;
        int ph;
        logic [3:0] ready_pat;
        ready_pat = 4'b1001;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        cyc = 1;
        check("busy_after_start", busy_a, 1);
        for (int c = 0; c < 16; c++)
            for (int h = 0; h < 2; h++) begin
                check("a_out_drive", a_a, c);
                if (h == 0) check("no_valid_in_drive", bus_a.out_valid, 0);
                start_a = pulse && c == 5;
                step();
                cyc++;
            end
        start_a = 1'b0;
        idx = 0;
        ph = 0;
        while (idx < 16 && cyc < 200) begin
            bus_a.out_ready = bp ? ready_pat[ph % 4] : 1'b1;
            start_a = pulse && ph == 1;
            check("beat_valid", bus_a.out_valid, 1);
            check("beat_code", bus_a.out_code, vecs[idx].code);
            check("beat_resp", bus_a.out_resp, vecs[idx].resp);
            check("a_out_dump", a_a, 15);
            if (bus_a.out_ready) idx++;
            ph++;
            step();
            cyc++;
        end
        start_a = 1'b0;
        bus_a.out_ready = 1'b1;
        check("beat_count", idx, 16);
        check("done_pulse", done_a, 1);
        check("done_cycle", cyc, bp ? 65 : 49);
        check("busy_at_done", busy_a, 0);
        check("valid_at_done", bus_a.out_valid, 0);
        check("ones_cnt", ones_a, ONES);
        start_a = keep;
        step();
        check("done_one_cycle", done_a, 0);
        check("idle_busy", busy_a, 0);
        check("ones_held", ones_a, ONES);
    endtask
    initial begin
        vecs[0]  = '{4'd0,  3'b000};
        vecs[1]  = '{4'd1,  3'b010};
        vecs[2]  = '{4'd2,  3'b010};
        vecs[3]  = '{4'd3,  3'b001};
        vecs[4]  = '{4'd4,  3'b110};
        vecs[5]  = '{4'd5,  3'b100};
        vecs[6]  = '{4'd6,  3'b100};
        vecs[7]  = '{4'd7,  3'b111};
        vecs[8]  = '{4'd8,  3'b110};
        vecs[9]  = '{4'd9,  3'b100};
        vecs[10] = '{4'd10, 3'b100};
        vecs[11] = '{4'd11, 3'b111};
        vecs[12] = '{4'd12, 3'b100};
        vecs[13] = '{4'd13, 3'b110};
        vecs[14] = '{4'd14, 3'b110};
        vecs[15] = '{4'd15, 3'b101};
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        step();
        step();
        check("rst_a_out", a_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_valid", bus_a.out_valid, 0);
        check("rst_ones", ones_a, 0);
        check("rst_b_a_out", a_b, 0);
        rst_n = 1'b1;
        step();
        run_a(1'b0, 1'b0, 1'b0);
        run_a(1'b1, 1'b0, 1'b0);
        run_a(1'b0, 1'b1, 1'b1);
        run_a(1'b0, 1'b0, 1'b0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (14) step();
        check("mid_a_out", a_a, 7);
        rst_n = 1'b0;
        step();
        check("abort_a_out", a_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_valid", bus_a.out_valid, 0);
        check("abort_code", bus_a.out_code, 0);
        check("abort_resp", bus_a.out_resp, 0);
        check("abort_ones", ones_a, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done", done_a, 0);
            check("abort_stay_idle", busy_a, 0);
            step();
        end
        run_a(1'b0, 1'b0, 1'b0);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int c = 0; c < 16; c++) begin
            check("h1_a_out", a_b, c);
            check("h1_busy", busy_b, 1);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            check("h1_valid", bus_b.out_valid, 1);
            check("h1_code", bus_b.out_code, vecs[i].code);
            check("h1_resp", bus_b.out_resp, vecs[i].resp);
            step();
        end
        check("h1_done", done_b, 1);
        check("h1_ones", ones_b, ONES);
        step();
        check("h1_done_one_cycle", done_b, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
